// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// serial_arith_pkg : shared types and defaults for the bit-serial arithmetic units
// Revision: 1.0
// ============================================================================
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam int SER_DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// full_subtractor : one-bit combinational subtract cell, d = x - y - bin
// Revision: 1.0
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor : bit-serial a - b, LSB first, WIDTH-cycle latency
// Revision: 1.0
// ============================================================================
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_bout;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        // w_d is the result MSB on the final bit
                        r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor : scoreboard bench for serial_subtractor, WIDTH = 8
// Revision: 1.0
// ============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] d;
        logic       bw;
        logic       ov;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic prev_valid = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, values on each handshake
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
            end else if (cyc - q[0].acc != WIDTH) begin
                errors++;
                $display("FAIL latency: got %0d expected %0d", cyc - q[0].acc, WIDTH);
            end
        end
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("diff", {24'd0, diff}, {24'd0, e.d});
            chk("borrow", {31'd0, borrow}, {31'd0, e.bw});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        end
        prev_valid = out_valid;
    end

    // Drive operands from just after a rising edge; returns on the accept edge + 1
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ed, input logic ebw, input logic eov,
                         output int acc);
        exp_t e;
        int   n = 0;
        acc      = -1;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        while (acc < 0 && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = ed; e.bw = ebw; e.ov = eov; e.acc = cyc + 1;
                q.push_back(e);
                acc = cyc + 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL done_timeout: got pending=%0d expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [7:0] va [7] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01};
    logic [7:0] vb [7] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h01, 8'hFF};
    logic [7:0] vd [7] = '{8'h02, 8'hFE, 8'h00, 8'h7F, 8'h80, 8'hFE, 8'h02};
    logic       vw [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       vo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int acc0, acc1, acc2;
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vd[i], vw[i], vo[i], acc0);
            wait_done();
        end

        // Back-to-back with in_valid asserted as soon as each accept completes
        issue(8'h40, 8'h01, 8'h3F, 1'b0, 1'b0, acc0);
        issue(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, acc1);
        issue(8'h90, 8'h20, 8'h70, 1'b0, 1'b1, acc2);
        chk("ii_first", acc1 - acc0, 32'd10);
        chk("ii_second", acc2 - acc1, 32'd10);
        wait_done();

        // New operands held valid during SHIFT must be ignored
        issue(8'h3C, 8'h0C, 8'h30, 1'b0, 1'b0, acc0);
        in_valid = 1'b1; a = 8'hFF; b = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();
        repeat (12) @(posedge clk);
        #1;

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1, acc0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_diff", {24'd0, diff}, 32'h4B);
            chk("bp_borrow", {31'd0, borrow}, 32'd0);
            chk("bp_overflow", {31'd0, overflow}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Reset during the third SHIFT cycle aborts the operation
        issue(8'h22, 8'h11, 8'h11, 1'b0, 1'b0, acc0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(q.pop_back());
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, acc0);
        wait_done();

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
